// File: rtl/iob_uart_console_bridge_pkg.sv
// Shared definitions for the UART console bridge.
// Contents: UART register map, FSM state encoding, the ENQ byte value,
// the init-sequence length and helpers that give the address and data of each init write.
package iob_uart_console_bridge_pkg;

  // UART register map
  localparam logic [2:0] REG_SOFTRESET = 3'd0;
  localparam logic [2:0] REG_DIV       = 3'd1;
  localparam logic [2:0] REG_TXDATA    = 3'd2;
  localparam logic [2:0] REG_TXEN      = 3'd3;
  localparam logic [2:0] REG_TXREADY   = 3'd4;
  localparam logic [2:0] REG_RXDATA    = 3'd5;
  localparam logic [2:0] REG_RXEN      = 3'd6;
  localparam logic [2:0] REG_RXREADY   = 3'd7;

  localparam logic [7:0]  ENQ_BYTE   = 8'h05;
  localparam int unsigned INIT_LEN   = 5;
  localparam int unsigned INIT_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_POLL_RX,
    ST_RD_RX,
    ST_POLL_TX,
    ST_WR_TX,
    ST_GAP
  } state_e;

  // Register targeted by init write number idx
  function automatic logic [2:0] init_addr(input logic [INIT_IDX_W-1:0] idx);
    case (idx)
      3'd0, 3'd1: init_addr = REG_SOFTRESET;
      3'd2:       init_addr = REG_DIV;
      3'd3:       init_addr = REG_TXEN;
      default:    init_addr = REG_RXEN;
    endcase
  endfunction

  // Value written by init write number idx
  function automatic logic [15:0] init_data(input logic [INIT_IDX_W-1:0] idx,
                                            input logic [15:0]           div);
    case (idx)
      3'd0:    init_data = 16'd1;
      3'd1:    init_data = 16'd0;
      3'd2:    init_data = div;
      default: init_data = 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/uart_bridge_fifo.sv
// Synchronous byte FIFO, depth 2**AW.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data write side,
// i_pop read side, o_data head byte (zero when empty), o_full, o_empty, o_level occupancy.
module uart_bridge_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [7:0]   i_data,
  input  logic         i_pop,
  output logic [7:0]   o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_level
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [7:0]    r_mem [0:(1 << AW) - 1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign o_level  = r_count;
  assign w_push   = i_push & ~o_full;
  assign w_pop    = i_pop & ~o_empty;
  // Head is forced to zero when empty so the output is clean out of reset
  assign o_data   = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/iob_uart_console_bridge.sv
// Bridges a host byte stream pair to a polled UART over a native bus master.
// Ports: clk, reset_n (async active-low), en (run enable), cfg_div (UART divider),
// tx_* host->UART stream, rx_* UART->host stream, m_* bus master request/response,
// init_done, enq_seen (sticky 0x05 received), tx_level/rx_level FIFO occupancy.
module iob_uart_console_bridge
  import iob_uart_console_bridge_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned POLL_GAP = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [15:0]           cfg_div,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready,
  output logic                  init_done,
  output logic                  enq_seen,
  output logic [FIFO_AW:0]      tx_level,
  output logic [FIFO_AW:0]      rx_level
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  state_e                  r_state;
  logic                    r_m_valid;
  logic [ADDR_W-1:0]       r_m_addr;
  logic [DATA_W-1:0]       r_m_wdata;
  logic [DATA_W/8-1:0]     r_m_wstrb;
  logic                    r_init_done;
  logic                    r_enq_seen;
  logic                    r_alive;
  logic [INIT_IDX_W-1:0]   r_init_idx;
  logic [15:0]             r_div;
  logic [GAP_W-1:0]        r_gap_cnt;

  logic       w_done;
  logic       w_tx_push;
  logic       w_tx_pop;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_unused_rdata;

  assign w_unused_rdata = ^m_rdata[DATA_W-1:8];

  // Accepted bus handshake this cycle
  assign w_done    = r_m_valid & m_ready;
  assign w_tx_pop  = w_done & (r_state == ST_WR_TX);
  assign w_rx_push = w_done & (r_state == ST_RD_RX);
  // r_alive keeps tx_ready low while reset is held, then high from the first edge
  assign w_tx_push = tx_valid & tx_ready;
  assign w_rx_pop  = rx_valid & rx_ready;

  assign tx_ready  = r_alive & ~w_tx_full;
  assign rx_valid  = ~w_rx_empty;
  assign m_valid   = r_m_valid;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_wstrb   = r_m_wstrb;
  assign init_done = r_init_done;
  assign enq_seen  = r_enq_seen;

  uart_bridge_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_tx_push),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  uart_bridge_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_rx_push),
    .i_data  (m_rdata[7:0]),
    .i_pop   (w_rx_pop),
    .o_data  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (rx_level)
  );

  // Control FSM and registered bus request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_m_valid   <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
      r_init_done <= 1'b0;
      r_enq_seen  <= 1'b0;
      r_alive     <= 1'b0;
      r_init_idx  <= '0;
      r_div       <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_rx_push && (m_rdata[7:0] == ENQ_BYTE)) r_enq_seen <= 1'b1;

      if (r_m_valid) begin
        // Outstanding request: hold everything until the slave accepts
        if (m_ready) begin
          r_m_valid <= 1'b0;
          r_m_addr  <= '0;
          r_m_wdata <= '0;
          r_m_wstrb <= '0;
          case (r_state)
            ST_INIT: begin
              if (r_init_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
                r_init_done <= 1'b1;
                r_state     <= ST_POLL_RX;
              end else begin
                r_init_idx <= r_init_idx + 1'b1;
              end
            end
            ST_POLL_RX: r_state <= m_rdata[0] ? ST_RD_RX : ST_POLL_TX;
            ST_RD_RX:   r_state <= ST_POLL_TX;
            ST_POLL_TX: r_state <= m_rdata[0] ? ST_WR_TX : ST_GAP;
            ST_WR_TX:   r_state <= ST_GAP;
            default:    r_state <= ST_IDLE;
          endcase
          // Disable takes effect once the in-flight transfer has finished
          if (!en) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b0;
          end
        end
      end else if (!en) begin
        r_state     <= ST_IDLE;
        r_init_done <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!r_init_done) begin
              r_div      <= cfg_div;
              r_init_idx <= '0;
              r_state    <= ST_INIT;
            end
          end
          ST_INIT: begin
            r_m_valid <= 1'b1;
            r_m_addr  <= ADDR_W'(init_addr(r_init_idx));
            r_m_wdata <= DATA_W'(init_data(r_init_idx, r_div));
            r_m_wstrb <= '1;
          end
          ST_POLL_RX: begin
            // No room for another byte: skip the RX side entirely
            if (w_rx_full) begin
              r_state <= ST_POLL_TX;
            end else begin
              r_m_valid <= 1'b1;
              r_m_addr  <= ADDR_W'(REG_RXREADY);
              r_m_wdata <= '0;
              r_m_wstrb <= '0;
            end
          end
          ST_RD_RX: begin
            r_m_valid <= 1'b1;
            r_m_addr  <= ADDR_W'(REG_RXDATA);
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
          end
          ST_POLL_TX: begin
            // Nothing to send: skip the TX side entirely
            if (w_tx_empty) begin
              r_state <= ST_GAP;
            end else begin
              r_m_valid <= 1'b1;
              r_m_addr  <= ADDR_W'(REG_TXREADY);
              r_m_wdata <= '0;
              r_m_wstrb <= '0;
            end
          end
          ST_WR_TX: begin
            r_m_valid <= 1'b1;
            r_m_addr  <= ADDR_W'(REG_TXDATA);
            r_m_wdata <= DATA_W'(w_tx_head);
            r_m_wstrb <= '1;
          end
          ST_GAP: begin
            if (r_gap_cnt == GAP_W'(POLL_GAP)) begin
              r_gap_cnt <= '0;
              r_state   <= ST_POLL_RX;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
